// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: unsigned binary -> packed BCD digits.
// Saturates operands above 10^DIGITS-1 to all-nines and flags overflow.
//
// Ports:
//   clk_i      : clock, rising edge
//   reset_i    : synchronous reset, active low
//   start_i    : conversion request, sampled only while idle
//   bin_i      : unsigned binary operand, sampled on accepted start
//   ready_o    : high while idle (a start will be accepted)
//   done_o     : one-cycle pulse, BCD_o/overflow_o freshly updated
//   BCD_o      : packed BCD result, digit 0 in [3:0]
//   overflow_o : last operand exceeded 10^DIGITS-1 and was saturated
module bin_to_bcd_converter #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   BCD_o,
  output logic                  overflow_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] dec_max(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_DEC = dec_max(DIGITS);
  localparam logic [BIN_W-1:0] SAT_VAL = MAX_DEC[BIN_W-1:0];
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(BIN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [BIN_W-1:0]     bin_work;
  logic [BIN_W-1:0]     bin_work_n;
  logic [BCD_W-1:0]     bcd_work;
  logic [BCD_W-1:0]     bcd_work_n;
  logic [BCD_W-1:0]     bcd_adj;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic                 ovf_next;
  logic                 ovf_next_n;
  logic [BCD_W-1:0]     bcd_out_n;
  logic                 ovf_out_n;
  logic                 done_n;
  logic                 too_big;

  assign too_big = 64'(bin_i) > MAX_DEC;

  // Add-3 correction: any digit >= 5 would carry past 9 once doubled.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_n    = state;
    bin_work_n = bin_work;
    bcd_work_n = bcd_work;
    cnt_n      = cnt;
    ovf_next_n = ovf_next;
    bcd_out_n  = BCD_o;
    ovf_out_n  = overflow_o;
    done_n     = 1'b0;
    ready_o    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          bin_work_n = too_big ? SAT_VAL : bin_i;
          ovf_next_n = too_big;
          bcd_work_n = '0;
          cnt_n      = ITERS;
          state_n    = OP;
        end
      end
      OP: begin
        // Shift {bcd, bin} left; bin MSB enters digit 0.
        bcd_work_n = {bcd_adj[BCD_W-2:0], bin_work[BIN_W-1]};
        bin_work_n = {bin_work[BIN_W-2:0], 1'b0};
        cnt_n      = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        bcd_out_n = bcd_work;
        ovf_out_n = ovf_next;
        done_n    = 1'b1;
        state_n   = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      bin_work   <= '0;
      bcd_work   <= '0;
      cnt        <= '0;
      ovf_next   <= 1'b0;
      BCD_o      <= '0;
      overflow_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_n;
      bin_work   <= bin_work_n;
      bcd_work   <= bcd_work_n;
      cnt        <= cnt_n;
      ovf_next   <= ovf_next_n;
      BCD_o      <= bcd_out_n;
      overflow_o <= ovf_out_n;
      done_o     <= done_n;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Testbench for bin_to_bcd_converter: vector table, scoreboard queue,
// handwritten corner sequences and a random sweep against a decimal model.
module tb_bin_to_bcd_converter;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [26:0] bin_i = '0;
  logic        ready_o;
  logic        done_o;
  logic [31:0] BCD_o;
  logic        overflow_o;

  bin_to_bcd_converter #(.BIN_W(27), .DIGITS(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .bin_i      (bin_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .BCD_o      (BCD_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [26:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t        vecs[15];
  logic [32:0] sb_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          dcount = 0;

  always @(negedge clk_i) begin
    if (done_o) dcount++;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [32:0] golden(input logic [26:0] b);
    logic [31:0] r;
    int unsigned v;
    logic        ovf;
    v   = 32'(b);
    ovf = v > 99999999;
    if (ovf) v = 99999999;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {ovf, r};
  endfunction

  task automatic start_conv(input logic [26:0] b, input logic [32:0] exp);
    int k;
    k = 0;
    @(negedge clk_i);
    while (!ready_o && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    if (!ready_o) check("ready_wait", 0, 1);
    bin_i   = b;
    start_i = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    bin_i   = 27'($urandom);
  endtask

  task automatic wait_done(input string name, output int lat);
    logic [32:0] e;
    lat = 0;
    while (lat < 60) begin
      @(negedge clk_i);
      if (done_o) break;
      lat++;
    end
    if (!done_o) begin
      check({name, "_timeout"}, 0, 1);
    end else if (sb_q.size() == 0) begin
      check({name, "_unexpected_done"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({name, "_bcd"}, 64'(BCD_o), 64'(e[31:0]));
      check({name, "_ovf"}, 64'(overflow_o), 64'(e[32]));
      check({name, "_ready"}, 64'(ready_o), 64'd1);
    end
  endtask

  initial begin
    int lat;
    int d0;
    logic [26:0] r;

    vecs[0]  = '{27'd0,         32'h00000000, 1'b0};
    vecs[1]  = '{27'd12345678,  32'h12345678, 1'b0};
    vecs[2]  = '{27'd99999999,  32'h99999999, 1'b0};
    vecs[3]  = '{27'd100000000, 32'h99999999, 1'b1};
    vecs[4]  = '{27'd134217727, 32'h99999999, 1'b1};
    vecs[5]  = '{27'd5,         32'h00000005, 1'b0};
    vecs[6]  = '{27'd1,         32'h00000001, 1'b0};
    vecs[7]  = '{27'd9,         32'h00000009, 1'b0};
    vecs[8]  = '{27'd10,        32'h00000010, 1'b0};
    vecs[9]  = '{27'd99,        32'h00000099, 1'b0};
    vecs[10] = '{27'd100,       32'h00000100, 1'b0};
    vecs[11] = '{27'd65535,     32'h00065535, 1'b0};
    vecs[12] = '{27'd10000000,  32'h10000000, 1'b0};
    vecs[13] = '{27'd98765432,  32'h98765432, 1'b0};
    vecs[14] = '{27'd100000001, 32'h99999999, 1'b1};

    // Reset
    reset_i = 1'b0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_bcd", 64'(BCD_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    reset_i = 1'b1;
    @(posedge clk_i);

    // First conversion, latency and pulse width
    start_conv(27'd7, {1'b0, 32'h00000007});
    wait_done("seven", lat);
    check("seven_latency", 64'(lat), 64'd28);
    @(negedge clk_i);
    check("seven_pulse_width", 64'(done_o), 64'd0);
    check("seven_hold", 64'(BCD_o), 64'h7);

    // Vector table
    for (int i = 0; i < 15; i++) begin
      start_conv(vecs[i].bin, {vecs[i].ovf, vecs[i].bcd});
      wait_done($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd28);
    end

    // Start held across DONE: second conversion starts on return to idle
    start_i = 1'b1;
    bin_i   = 27'd11;
    sb_q.push_back({1'b0, 32'h00000011});
    wait_done("held_a", lat);
    bin_i = 27'd22;
    sb_q.push_back({1'b0, 32'h00000022});
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done("held_b", lat);
    check("held_b_throughput", 64'(lat), 64'd28);

    // Start held two cycles, then a stray start mid-conversion
    @(negedge clk_i);
    bin_i   = 27'd1234;
    start_i = 1'b1;
    sb_q.push_back({1'b0, 32'h00001234});
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (8) @(negedge clk_i);
    bin_i   = 27'd42;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    bin_i   = 27'd0;
    wait_done("ignore", lat);
    @(posedge clk_i);
    d0 = dcount;
    repeat (40) @(posedge clk_i);
    check("ignore_no_extra_done", 64'(dcount), 64'(d0));
    check("ignore_bcd_hold", 64'(BCD_o), 64'h1234);

    // Reset mid-conversion aborts it
    start_conv(27'd4321, {1'b0, 32'h00004321});
    repeat (9) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    void'(sb_q.pop_back());
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(negedge clk_i);
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_bcd", 64'(BCD_o), 64'd0);
    d0 = dcount;
    repeat (40) @(posedge clk_i);
    check("abort_no_done", 64'(dcount), 64'(d0));
    start_conv(27'd87654321, {1'b0, 32'h87654321});
    wait_done("after_abort", lat);
    check("after_abort_latency", 64'(lat), 64'd28);

    // Random sweep against decimal model
    for (int i = 0; i < 1000; i++) begin
      r = 27'($urandom);
      start_conv(r, golden(r));
      wait_done($sformatf("rand%0d", i), lat);
    end

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
